// File: rtl/node_pkg.sv
// Types shared by the node datapath and its trainer sequencer.
package node_pkg;

  localparam int unsigned NODE_WIDTH = 8;

  typedef logic signed [NODE_WIDTH-1:0]   operand_t;
  typedef logic signed [2*NODE_WIDTH-1:0] product_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_ISSUE,
    ST_WAIT,
    ST_DELTA,
    ST_SINK,
    ST_REPORT,
    ST_DONE
  } trainer_state_e;

  // Counter width that stays legal when the count collapses to a single value.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/node_trainer_if.sv
// Streams between the trainer, its sample/target source, the driven node and the result sink.
interface node_trainer_if #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 2
);
  logic                       sample_valid;
  logic                       sample_ready;
  logic [DEPTH*WIDTH-1:0]     sample_data;
  logic [WIDTH-1:0]           sample_target;
  logic                       node_train;
  logic                       node_input_valid;
  logic                       node_input_ready;
  logic [DEPTH*WIDTH-1:0]     node_input_data;
  logic                       node_output_valid;
  logic                       node_output_ready;
  logic [WIDTH-1:0]           node_output_data;
  logic                       node_delta_valid;
  logic                       node_delta_ready;
  logic [2*WIDTH-1:0]         node_delta_data;
  logic                       node_error_valid;
  logic                       node_error_ready;
  logic [DEPTH*2*WIDTH-1:0]   node_error_data;
  logic                       result_valid;
  logic                       result_ready;
  logic [WIDTH-1:0]           result_data;
  logic [2*WIDTH-1:0]         result_error;

  modport master (
    input  sample_valid, sample_data, sample_target,
    input  node_input_ready, node_output_valid, node_output_data,
    input  node_delta_ready, node_error_valid, node_error_data, result_ready,
    output sample_ready, node_train, node_input_valid, node_input_data,
    output node_output_ready, node_delta_valid, node_delta_data,
    output node_error_ready, result_valid, result_data, result_error
  );

  modport slave (
    output sample_valid, sample_data, sample_target,
    output node_input_ready, node_output_valid, node_output_data,
    output node_delta_ready, node_error_valid, node_error_data, result_ready,
    input  sample_ready, node_train, node_input_valid, node_input_data,
    input  node_output_ready, node_delta_valid, node_delta_data,
    input  node_error_ready, result_valid, result_data, result_error
  );
endinterface

// File: rtl/node_trainer_error_unit.sv
// Signed output error, its magnitude, and the per-epoch |error| accumulator with snapshot.
module error_unit #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned ACC_W = 2*WIDTH + 3
) (
  input  logic               clock_i,
  input  logic               reset_i,
  input  logic               clear_i,
  input  logic               add_i,
  input  logic               snapshot_i,
  input  logic [WIDTH-1:0]   target_i,
  input  logic [WIDTH-1:0]   activation_i,
  output logic [2*WIDTH-1:0] error_o,
  output logic [ACC_W-1:0]   epoch_error_o
);
  logic [2*WIDTH-1:0] diff;
  logic [2*WIDTH-1:0] magnitude;
  logic [2*WIDTH-1:0] error_d, error_q;
  logic [ACC_W-1:0]   acc_d, acc_q;
  logic [ACC_W-1:0]   epoch_d, epoch_q;

  // Both operands are sign-extended first, so -128 - 127 = -255 never wraps.
  assign diff      = {{WIDTH{target_i[WIDTH-1]}}, target_i}
                   - {{WIDTH{activation_i[WIDTH-1]}}, activation_i};
  assign magnitude = diff[2*WIDTH-1] ? -diff : diff;

  always_comb begin
    // NOTE: every variable gets a default before any branch, so no latch can be inferred.
    error_d = error_q;
    acc_d   = acc_q;
    epoch_d = epoch_q;
    if (snapshot_i) epoch_d = acc_q;
    if (add_i) begin
      error_d = diff;
      acc_d   = acc_q + {{(ACC_W-2*WIDTH){1'b0}}, magnitude};
    end
    if (clear_i) acc_d = '0;
  end

  always_ff @(posedge clock_i) begin
    // NOTE: registers use non-blocking assignment so all of them sample pre-edge values.
    if (reset_i) begin
      error_q <= '0;
      acc_q   <= '0;
      epoch_q <= '0;
    end else begin
      error_q <= error_d;
      acc_q   <= acc_d;
      epoch_q <= epoch_d;
    end
  end

  assign error_o       = error_q;
  assign epoch_error_o = epoch_q;
endmodule

// File: rtl/node_trainer.sv
// Sequences samples through one node, optionally back-propagating the output error, for a set number of epochs.
module node_trainer
  import node_pkg::*;
#(
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned DEPTH   = 2,
  parameter int unsigned SAMPLES = 4,
  parameter int unsigned EPOCHS  = 1
) (
  input  logic                                  clock_i,
  input  logic                                  reset_i,
  input  logic                                  start_i,
  input  logic                                  train_i,
  output logic                                  busy_o,
  output logic                                  done_o,
  output logic [2*WIDTH+$clog2(SAMPLES):0]      epoch_error_o,
  node_trainer_if.master                        bus_if
);
  localparam int unsigned SCNT_W = cnt_width(SAMPLES);
  localparam int unsigned ECNT_W = cnt_width(EPOCHS);
  localparam int unsigned ACC_W  = 2*WIDTH + $clog2(SAMPLES) + 1;
  localparam logic [SCNT_W-1:0] LAST_SAMPLE = SCNT_W'(SAMPLES - 1);
  localparam logic [ECNT_W-1:0] LAST_EPOCH  = ECNT_W'(EPOCHS - 1);

  trainer_state_e         state_d, state_q;
  logic                   mode_d, mode_q;
  logic [SCNT_W-1:0]      sample_cnt_d, sample_cnt_q;
  logic [ECNT_W-1:0]      epoch_cnt_d, epoch_cnt_q;
  logic [DEPTH*WIDTH-1:0] operands_d, operands_q;
  logic [WIDTH-1:0]       target_d, target_q;
  logic [WIDTH-1:0]       activation_d, activation_q;
  logic                   err_clear, err_add, err_snapshot;
  logic [2*WIDTH-1:0]     error;
  logic                   unused_error_data;

  always_comb begin
    state_d      = state_q;
    mode_d       = mode_q;
    sample_cnt_d = sample_cnt_q;
    epoch_cnt_d  = epoch_cnt_q;
    operands_d   = operands_q;
    target_d     = target_q;
    activation_d = activation_q;
    err_clear    = 1'b0;
    err_add      = 1'b0;
    err_snapshot = 1'b0;
    bus_if.sample_ready      = 1'b0;
    bus_if.node_input_valid  = 1'b0;
    bus_if.node_output_ready = 1'b0;
    bus_if.node_delta_valid  = 1'b0;
    bus_if.node_error_ready  = 1'b0;
    bus_if.result_valid      = 1'b0;
    unique case (state_q)
      ST_IDLE: if (start_i) begin
        mode_d       = train_i;
        sample_cnt_d = '0;
        epoch_cnt_d  = '0;
        err_clear    = 1'b1;
        state_d      = ST_FETCH;
      end
      ST_FETCH: begin
        bus_if.sample_ready = 1'b1;
        if (bus_if.sample_valid) begin
          operands_d = bus_if.sample_data;
          target_d   = bus_if.sample_target;
          state_d    = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        bus_if.node_input_valid = 1'b1;
        if (bus_if.node_input_ready) state_d = ST_WAIT;
      end
      ST_WAIT: begin
        bus_if.node_output_ready = 1'b1;
        if (bus_if.node_output_valid) begin
          activation_d = bus_if.node_output_data;
          err_add      = 1'b1;
          state_d      = mode_q ? ST_DELTA : ST_REPORT;
        end
      end
      ST_DELTA: begin
        bus_if.node_delta_valid = 1'b1;
        if (bus_if.node_delta_ready) state_d = ST_SINK;
      end
      ST_SINK: begin
        bus_if.node_error_ready = 1'b1;
        if (bus_if.node_error_valid) state_d = ST_REPORT;
      end
      ST_REPORT: begin
        bus_if.result_valid = 1'b1;
        if (bus_if.result_ready) begin
          if (sample_cnt_q != LAST_SAMPLE) begin
            sample_cnt_d = sample_cnt_q + SCNT_W'(1);
            state_d      = ST_FETCH;
          end else if (mode_q && (epoch_cnt_q != LAST_EPOCH)) begin
            err_snapshot = 1'b1;
            err_clear    = 1'b1;
            sample_cnt_d = '0;
            epoch_cnt_d  = epoch_cnt_q + ECNT_W'(1);
            state_d      = ST_FETCH;
          end else begin
            err_snapshot = 1'b1;
            state_d      = ST_DONE;
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q      <= ST_IDLE;
      mode_q       <= 1'b0;
      sample_cnt_q <= '0;
      epoch_cnt_q  <= '0;
      operands_q   <= '0;
      target_q     <= '0;
      activation_q <= '0;
    end else begin
      state_q      <= state_d;
      mode_q       <= mode_d;
      sample_cnt_q <= sample_cnt_d;
      epoch_cnt_q  <= epoch_cnt_d;
      operands_q   <= operands_d;
      target_q     <= target_d;
      activation_q <= activation_d;
    end
  end

  error_unit #(.WIDTH(WIDTH), .ACC_W(ACC_W)) u_error_unit (
    .clock_i       (clock_i),
    .reset_i       (reset_i),
    .clear_i       (err_clear),
    .add_i         (err_add),
    .snapshot_i    (err_snapshot),
    .target_i      (target_q),
    .activation_i  (bus_if.node_output_data),
    .error_o       (error),
    .epoch_error_o (epoch_error_o)
  );

  // The node's back-propagated input gradients have no consumer here.
  assign unused_error_data = ^bus_if.node_error_data;

  assign busy_o                 = (state_q != ST_IDLE);
  assign done_o                 = (state_q == ST_DONE);
  assign bus_if.node_train      = mode_q;
  assign bus_if.node_input_data = operands_q;
  assign bus_if.node_delta_data = error;
  assign bus_if.result_data     = activation_q;
  assign bus_if.result_error    = error;
endmodule
